// File: rtl/pzbcm_onehot_violation_monitor_if.sv
// Purpose : bundles the monitored vector, its qualifier, the CSR clear request
//           and the monitor's status outputs into one connection.
// Ports   : i_valid, i_bits, i_clear  (toward the monitor)
//           o_error, o_error_bits, o_error_count, o_saturated, o_irq (from it)
// Modports: master = producer/CSR side, slave = monitor side.
interface pzbcm_onehot_violation_monitor_if #(
  parameter int N             = 2,
  parameter int COUNTER_WIDTH = 8
) ();
  logic                     i_valid;
  logic [N-1:0]             i_bits;
  logic                     i_clear;
  logic                     o_error;
  logic [N-1:0]             o_error_bits;
  logic [COUNTER_WIDTH-1:0] o_error_count;
  logic                     o_saturated;
  logic                     o_irq;

  modport master (
    output i_valid, i_bits, i_clear,
    input  o_error, o_error_bits, o_error_count, o_saturated, o_irq
  );

  modport slave (
    input  i_valid, i_bits, i_clear,
    output o_error, o_error_bits, o_error_count, o_saturated, o_irq
  );
endinterface

// File: rtl/pzbcm_onehot_violation_monitor.sv
// Purpose : registered one-hot violation monitor. A qualified vector with two or
//           more bits set (or, optionally, no bit set) raises a sticky error,
//           captures the first offending vector, counts further violations with
//           saturation and pulses an interrupt once per entry into the error state.
// Ports   : i_clk  clock
//           i_rst  asynchronous active-high reset
//           mon    slave side of pzbcm_onehot_violation_monitor_if
//
// state | meaning
// IDLE  | no violation seen since reset/clear
// ERROR | violation latched; bits/count hold history until clear
module pzbcm_onehot_violation_monitor #(
  parameter int N             = 2,
  parameter int COUNTER_WIDTH = 8,
  parameter bit ZERO_IS_ERROR = 1'b0
) (
  input logic                           i_clk,
  input logic                           i_rst,
  pzbcm_onehot_violation_monitor_if.slave mon
);

  localparam logic [0:0]               IDLE      = 1'b0;
  localparam logic [0:0]               ERROR     = 1'b1;
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

  logic [0:0]               state, state_next;
  logic [N-1:0]             error_bits, error_bits_next;
  logic [COUNTER_WIDTH-1:0] count, count_next;
  logic                     irq, irq_next;
  logic                     multi_hot;
  logic                     all_zero;
  logic                     viol;

  // Clearing the lowest set bit leaves something behind only if >= 2 bits were set.
  assign multi_hot = |(mon.i_bits & (mon.i_bits - N'(1)));
  assign all_zero  = ~|mon.i_bits;
  // i_valid gates everything so unqualified (possibly X) bits never reach state.
  assign viol      = mon.i_valid && (multi_hot || (ZERO_IS_ERROR && all_zero));

  always_comb begin
    state_next      = state;
    error_bits_next = error_bits;
    count_next      = count;
    irq_next        = 1'b0;
    if (state == IDLE) begin
      if (viol) begin
        state_next      = ERROR;
        error_bits_next = mon.i_bits;
        count_next      = COUNT_ONE;
        irq_next        = 1'b1;
      end
    end else begin
      if (viol && mon.i_clear) begin
        // Clear wipes the old history but the same-cycle violation starts a new one.
        error_bits_next = mon.i_bits;
        count_next      = COUNT_ONE;
        irq_next        = 1'b1;
      end else if (viol) begin
        if (count != COUNT_MAX) begin
          count_next = count + COUNT_ONE;
        end
      end else if (mon.i_clear) begin
        state_next      = IDLE;
        error_bits_next = '0;
        count_next      = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      error_bits <= '0;
      count      <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= state_next;
      error_bits <= error_bits_next;
      count      <= count_next;
      irq        <= irq_next;
    end
  end

  assign mon.o_error       = (state == ERROR);
  assign mon.o_error_bits  = error_bits;
  assign mon.o_error_count = count;
  assign mon.o_saturated   = (count == COUNT_MAX);
  assign mon.o_irq         = irq;

endmodule
